// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the line bus to word-port sequencer.
package cpu_bus_pkg;

    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned LINE_WIDTH     = 128;
    localparam int unsigned BEAT_W         = 2;
    localparam logic [WORD_WIDTH-1:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        RESP,
        DRAIN
    } state_e;

    typedef logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] line_t;

endpackage

// File: rtl/line_bus_controller_line_buffer.sv
// Four-word read line buffer with word-indexed write enable.
module line_buffer
    import cpu_bus_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [BEAT_W-1:0]     idx_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    output line_t                 line_o
);

    line_t line_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            line_q <= '0;
        end else if (we_i) begin
            line_q[idx_i] <= wdata_i;
        end
    end

    assign line_o = line_q;

endmodule

// File: rtl/line_bus_controller.sv
// Splits one 128-bit line transaction into four in-order 32-bit beats on a
// word-wide memory port; read beats are assembled into the line buffer.
module line_bus_controller
    import cpu_bus_pkg::*;
#(
    parameter int unsigned BUS_ADDRESS_WIDTH = 20,
    parameter int unsigned TIMEOUT_CYCLES    = 255
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [BUS_ADDRESS_WIDTH-5:0] line_addr_i,
    input  logic [LINE_WIDTH-1:0]        line_data_i,
    input  logic                         line_we_i,
    input  logic                         line_valid_i,
    output logic [LINE_WIDTH-1:0]        line_data_o,
    output logic                         line_valid_o,
    output logic                         busy_o,
    output logic                         err_o,
    output logic [BUS_ADDRESS_WIDTH-3:0] mem_addr_o,
    output logic [WORD_WIDTH-1:0]        mem_wdata_o,
    output logic                         mem_we_o,
    output logic                         mem_req_o,
    input  logic                         mem_gnt_i,
    input  logic [WORD_WIDTH-1:0]        mem_rdata_i,
    input  logic                         mem_rvalid_i
);

    localparam int unsigned LAW   = BUS_ADDRESS_WIDTH - 4;
    localparam int unsigned WAW   = BUS_ADDRESS_WIDTH - 2;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [LAW-1:0]        addr_q, addr_d;
    line_t                 wline_q, wline_d;
    logic                  we_q, we_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  req_q, req_d;
    logic [WAW-1:0]        maddr_q, maddr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mwe_q, mwe_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;

    logic                  buf_we_c;
    logic [WORD_WIDTH-1:0] buf_wdata_c;
    logic                  advance_c;
    logic                  timeout_c;
    logic [BEAT_W-1:0]     beat_n_c;
    line_t                 rline_c;

    line_buffer u_line_buffer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (buf_we_c),
        .idx_i   (beat_q),
        .wdata_i (buf_wdata_c),
        .line_o  (rline_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        wline_d     = wline_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        req_d       = req_q;
        maddr_d     = maddr_q;
        wdata_d     = wdata_q;
        mwe_d       = mwe_q;
        valid_d     = 1'b0;
        busy_d      = busy_q;
        buf_we_c    = 1'b0;
        buf_wdata_c = mem_rdata_i;
        advance_c   = 1'b0;
        beat_n_c    = beat_q + BEAT_W'(1);
        timeout_c   = (TIMEOUT_CYCLES != 0) && !mem_rvalid_i &&
                      (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        case (state_q)
            IDLE: begin
                if (line_valid_i) begin
                    addr_d  = line_addr_i;
                    wline_d = line_data_i;
                    we_d    = line_we_i;
                    beat_d  = '0;
                    state_d = ISSUE;
                    req_d   = 1'b1;
                    maddr_d = {line_addr_i, BEAT_W'(0)};
                    wdata_d = line_data_i[WORD_WIDTH-1:0];
                    mwe_d   = line_we_i;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    if (we_q) begin
                        advance_c = 1'b1;
                    end else begin
                        state_d = WAIT_R;
                        cnt_d   = '0;
                        req_d   = 1'b0;
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    buf_we_c  = 1'b1;
                    advance_c = 1'b1;
                end else if (timeout_c) begin
                    buf_we_c    = 1'b1;
                    buf_wdata_c = TIMEOUT_FILL;
                    err_d       = 1'b1;
                    advance_c   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                // A held request must not start a second transaction
                if (!line_valid_i) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase

        if (advance_c) begin
            if (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) begin
                state_d = RESP;
                req_d   = 1'b0;
                valid_d = 1'b1;
            end else begin
                beat_d  = beat_n_c;
                state_d = ISSUE;
                req_d   = 1'b1;
                maddr_d = {addr_q, beat_n_c};
                wdata_d = wline_q[beat_n_c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
            mwe_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            mwe_q   <= mwe_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign line_data_o  = rline_c;
    assign line_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign err_o        = err_q;
    assign mem_addr_o   = maddr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_we_o     = mwe_q;
    assign mem_req_o    = req_q;

endmodule

// File: tb/tb_line_bus_controller.sv
// Bench for line_bus_controller: directed table, reset-abort sequence and
// randomized line transactions against a word-memory reference model.
`timescale 1ns/1ps
module tb_line_bus_controller;
    import cpu_bus_pkg::*;

    localparam int unsigned AW  = 20;
    localparam int unsigned LAW = AW - 4;
    localparam int unsigned WAW = AW - 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [LAW-1:0]    line_addr_i;
    logic [127:0]      line_data_i;
    logic              line_we_i;
    logic              line_valid_i;
    logic [127:0]      line_data_o;
    logic              line_valid_o;
    logic              busy_o;
    logic              err_o;
    logic [WAW-1:0]    mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_we_o;
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [31:0]       mem_rdata_i;
    logic              mem_rvalid_i;

    line_bus_controller #(.BUS_ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .line_addr_i(line_addr_i), .line_data_i(line_data_i), .line_we_i(line_we_i),
        .line_valid_i(line_valid_i), .line_data_o(line_data_o), .line_valid_o(line_valid_o),
        .busy_o(busy_o), .err_o(err_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_we_o(mem_we_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Word memory: content of word address wa is wa*4+1
    function automatic logic [31:0] mem_fn(input logic [WAW-1:0] wa);
        return 32'({wa, 2'b00}) + 32'd1;
    endfunction

    function automatic logic [127:0] model_read(input logic [LAW-1:0] la, input int sup);
        logic [127:0] l;
        for (int k = 0; k < 4; k++)
            l[32*k +: 32] = (k == sup) ? TIMEOUT_FILL : mem_fn({la, 2'(k)});
        return l;
    endfunction

    typedef struct packed {
        logic [WAW-1:0] addr;
        logic           we;
        logic [31:0]    wdata;
    } beat_t;

    beat_t       beats_q[$];
    beat_t       cur_b, prev_b;
    int          gnt_stall = 0;
    int          rv_lat = 1;
    int          sup_beat = -1;
    int          stall_ctr = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = '0;
    int          grants_total = 0;
    int          pulses_total = 0;
    int          stab_err = 0;
    int          pulse_wide = 0;
    logic        prev_stall = 1'b0;
    logic        prev_lv = 1'b0;

    // Handshake monitor: records accepted beats and schedules read data
    always @(posedge clk_i) begin
        cur_b = {mem_addr_o, mem_we_o, mem_wdata_o};
        if (mem_req_o && mem_gnt_i) begin
            beats_q.push_back(cur_b);
            grants_total++;
            stall_ctr = 0;
            if (!mem_we_o && int'(mem_addr_o[1:0]) != sup_beat) begin
                pend_cnt  = rv_lat;
                pend_data = mem_fn(mem_addr_o);
            end
        end
        if (prev_stall && mem_req_o && cur_b != prev_b) stab_err++;
        prev_stall = mem_req_o && !mem_gnt_i;
        prev_b     = cur_b;
        if (line_valid_o) pulses_total++;
        if (line_valid_o && prev_lv) pulse_wide++;
        prev_lv = line_valid_o;
    end

    // Memory responder: grant after gnt_stall cycles, read data rv_lat after grant
    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = pend_data;
                end
            end
            if (mem_req_o && stall_ctr < gnt_stall) begin
                mem_gnt_i = 1'b0;
                stall_ctr++;
            end else begin
                mem_gnt_i = (stall_ctr >= gnt_stall);
            end
        end
    end

    task automatic run_txn(input string tag, input logic we, input logic [LAW-1:0] la,
                           input logic [127:0] wd, input int stall, input int lat,
                           input int hold, input int sup, input int exp_lat,
                           input logic [127:0] exp_line, input logic exp_err);
        int cyc;
        int p0;
        bit seen;
        beat_t b;
        gnt_stall = stall; rv_lat = lat; sup_beat = we ? -1 : sup;
        beats_q.delete();
        p0 = pulses_total;
        line_addr_i = la; line_data_i = wd; line_we_i = we; line_valid_i = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk_i);
            cyc++;
            seen = line_valid_o;
        end
        chk({tag, ".done"}, 128'(seen), 128'(1));
        if (exp_lat >= 0) chk({tag, ".latency"}, 128'(cyc), 128'(exp_lat));
        chk({tag, ".line"}, line_data_o, exp_line);
        chk({tag, ".err"}, 128'(err_o), 128'(exp_err));
        repeat (1 + hold) @(negedge clk_i);
        chk({tag, ".busy_drain"}, 128'(busy_o), 128'(1));
        line_valid_i = 1'b0;
        @(negedge clk_i);
        chk({tag, ".busy_idle"}, 128'(busy_o), 128'(0));
        chk({tag, ".pulses"}, 128'(pulses_total - p0), 128'(1));
        chk({tag, ".grants"}, 128'(beats_q.size()), 128'(4));
        for (int k = 0; k < 4 && k < beats_q.size(); k++) begin
            b = beats_q[k];
            chk($sformatf("%s.addr%0d", tag, k), 128'(b.addr), 128'({la, 2'(k)}));
            chk($sformatf("%s.we%0d", tag, k), 128'(b.we), 128'(we));
            if (we) chk($sformatf("%s.wdata%0d", tag, k), 128'(b.wdata), 128'(wd[32*k +: 32]));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".line_data"}, line_data_o, '0);
        chk({tag, ".ctl"}, 128'({line_valid_o, busy_o, err_o, mem_we_o, mem_req_o}), 128'(0));
        chk({tag, ".mem_addr"}, 128'(mem_addr_o), 128'(0));
        chk({tag, ".mem_wdata"}, 128'(mem_wdata_o), 128'(0));
    endtask

    typedef struct {
        logic           we;
        logic [LAW-1:0] la;
        logic [127:0]   wd;
        int             stall;
        int             lat;
        int             hold;
        int             sup;
        int             exp_lat;
        logic [127:0]   exp_line;
        logic           exp_err;
    } vec_t;

    vec_t         vecs[6];
    logic [127:0] model_buf;
    logic         model_err;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic           we;
        logic [LAW-1:0] la;
        logic [127:0]   wd;
        int             sup;
        int             g0;
        int             p0;
        int             cyc;

        vecs[0] = '{1'b0, 16'h0123, 128'h0, 0, 1, 0, -1, 9,
                    128'h0000123D_00001239_00001235_00001231, 1'b0};
        vecs[1] = '{1'b1, 16'h0004, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0, 1, 0, -1, 5,
                    128'h0000123D_00001239_00001235_00001231, 1'b0};
        vecs[2] = '{1'b1, 16'h0ABC, 128'h44444444_33333333_22222222_11111111, 3, 1, 0, -1, -1,
                    128'h0000123D_00001239_00001235_00001231, 1'b0};
        vecs[3] = '{1'b0, 16'h00A5, 128'h0, 1, 2, 4, -1, -1,
                    128'h00000A5D_00000A59_00000A55_00000A51, 1'b0};
        vecs[4] = '{1'b0, 16'h03FF, 128'h0, 0, 1, 0, 2, -1,
                    128'h00003FFD_DEADBEEF_00003FF5_00003FF1, 1'b1};
        vecs[5] = '{1'b0, 16'hFFFF, 128'h0, 2, 3, 1, -1, -1,
                    128'h000FFFFD_000FFFF9_000FFFF5_000FFFF1, 1'b1};

        rst_i = 1'b1; line_addr_i = '0; line_data_i = '0; line_we_i = 1'b0; line_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("v%0d", i), vecs[i].we, vecs[i].la, vecs[i].wd, vecs[i].stall,
                    vecs[i].lat, vecs[i].hold, vecs[i].sup, vecs[i].exp_lat,
                    vecs[i].exp_line, vecs[i].exp_err);

        // Reset while waiting for beat 1 read data; that data arrives after reset
        gnt_stall = 0; rv_lat = 5; sup_beat = -1;
        p0 = pulses_total; g0 = grants_total; cyc = 0;
        line_addr_i = 16'h0055; line_we_i = 1'b0; line_valid_i = 1'b1;
        while (grants_total < g0 + 2 && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        chk("abort.beat1_granted", 128'(grants_total - g0), 128'(2));
        @(negedge clk_i);
        rst_i = 1'b1; line_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk_zero("abort.reset");
        repeat (8) @(negedge clk_i);
        chk_zero("abort.late_rvalid");
        chk("abort.no_pulse", 128'(pulses_total - p0), 128'(0));
        model_err = 1'b0;
        model_buf = model_read(16'h0055, -1);
        run_txn("abort.next", 1'b0, 16'h0055, '0, 0, 1, 0, -1, 9, model_buf, model_err);

        for (int i = 0; i < 30; i++) begin
            we  = 1'($urandom_range(0, 1));
            la  = LAW'($urandom);
            wd  = {$urandom, $urandom, $urandom, $urandom};
            sup = (!we && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            if (!we) begin
                model_buf = model_read(la, sup);
                if (sup >= 0) model_err = 1'b1;
            end
            run_txn($sformatf("rnd%0d", i), we, la, wd, int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), sup, -1,
                    model_buf, model_err);
        end

        chk("addr_wdata_stable", 128'(stab_err), 128'(0));
        chk("pulse_single_cycle", 128'(pulse_wide), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
